// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic-array feed/drain schedulers.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Final wavefront step index of one tile: the last row finishes COLS-1 steps after it starts.
  function automatic int skew_last(input int rows, input int cols);
    return cols + rows - 2;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skew_window_decoder.sv
// Marks which rows are inside the diagonal streaming window at wavefront step t.
module skew_window_decoder
  import sa_pkg::*;
#(
  parameter int ROW  = 9,
  parameter int COLS = 9,
  parameter int TCW  = cnt_w(COLS + ROW - 1)
) (
  input  logic [TCW-1:0] t,
  output logic [ROW-1:0] active
);

  logic [31:0] t_ext_s;

  assign t_ext_s = 32'(t);

  for (genvar r = 0; r < ROW; r++) begin : g_row
    if (r == 0) begin : g_first
      assign active[r] = (t_ext_s < 32'(COLS));
    end else begin : g_other
      assign active[r] = (t_ext_s >= 32'(r)) && (t_ext_s < 32'(r + COLS));
    end
  end

endmodule

// File: rtl/skew_feed_scheduler.sv
// Drives per-row FIFO reads so row r trails row 0 by r cycles, freezing the
// whole wavefront whenever the array or any in-window FIFO cannot proceed.
module skew_feed_scheduler
  import sa_pkg::*;
#(
  parameter int ROW  = 9,
  parameter int COLS = 9,
  parameter int TW   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [TW-1:0]   i_num_tiles,
  input  logic [ROW-1:0]  i_fifo_empty,
  input  logic            i_array_ready,
  output logic [ROW-1:0]  o_read_enable,
  output logic [ROW-1:0]  o_valid_mask,
  output logic            o_busy,
  output logic            o_done
);

  localparam int LAST = skew_last(ROW, COLS);
  localparam int TCW  = cnt_w(COLS + ROW - 1);

  state_e         state_r;
  state_e         state_nx_s;
  logic [TCW-1:0] t_r;
  logic [TCW-1:0] t_nx_s;
  logic [TW-1:0]  tiles_r;
  logic [TW-1:0]  tiles_nx_s;
  logic [ROW-1:0] active_s;
  logic [ROW-1:0] read_enable_s;
  logic [ROW-1:0] valid_mask_r;
  logic           stall_s;
  logic           busy_r;
  logic           done_r;

  skew_window_decoder #(
    .ROW  (ROW),
    .COLS (COLS),
    .TCW  (TCW)
  ) u_window (
    .t      (t_r),
    .active (active_s)
  );

  // Empty flags of rows outside the window are deliberately ignored.
  assign stall_s = !i_array_ready || (|(active_s & i_fifo_empty));

  // Read strobes: whole current window, or nothing while frozen / not feeding.
  always_comb begin
    read_enable_s = '0;
    if ((state_r == ST_FEED) && !stall_s) begin
      read_enable_s = active_s;
    end else begin
      read_enable_s = '0;
    end
  end

  // Next-state, step counter and tile counter.
  always_comb begin
    state_nx_s = state_r;
    t_nx_s     = t_r;
    tiles_nx_s = tiles_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start && (i_num_tiles != '0)) begin
          state_nx_s = ST_FEED;
          t_nx_s     = '0;
          tiles_nx_s = i_num_tiles;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (stall_s) begin
          state_nx_s = ST_FEED;
        end else if (t_r == TCW'(LAST)) begin
          t_nx_s = '0;
          if (tiles_r > TW'(1)) begin
            tiles_nx_s = tiles_r - TW'(1);
          end else begin
            tiles_nx_s = '0;
            state_nx_s = ST_FLUSH;
          end
        end else begin
          t_nx_s = t_r + TCW'(1);
        end
      end
      ST_FLUSH: state_nx_s = ST_DONE;
      ST_DONE:  state_nx_s = ST_IDLE;
      default: begin
        state_nx_s = ST_IDLE;
        t_nx_s     = '0;
        tiles_nx_s = '0;
      end
    endcase
  end

  // State, counters and registered outputs; busy/done track the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      t_r          <= '0;
      tiles_r      <= '0;
      valid_mask_r <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      t_r          <= t_nx_s;
      tiles_r      <= tiles_nx_s;
      valid_mask_r <= read_enable_s;
      busy_r       <= (state_nx_s != ST_IDLE);
      done_r       <= (state_nx_s == ST_DONE);
    end
  end

  assign o_read_enable = read_enable_s;
  assign o_valid_mask  = valid_mask_r;
  assign o_busy        = busy_r;
  assign o_done        = done_r;

endmodule

// File: tb/tb_skew_feed_scheduler.sv
// Self-checking bench for skew_feed_scheduler (ROW=3, COLS=4): fixed vector
// tables, directed corner sequences and random traffic against a progress model.
module tb_skew_feed_scheduler;

  localparam int R  = 3;
  localparam int C  = 4;
  localparam int P  = C + R - 1;
  localparam int TW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic [TW-1:0] i_num_tiles = '0;
  logic [R-1:0]  i_fifo_empty = '0;
  logic          i_array_ready = 1'b1;
  logic [R-1:0]  o_read_enable;
  logic [R-1:0]  o_valid_mask;
  logic          o_busy;
  logic          o_done;

  skew_feed_scheduler #(.ROW(R), .COLS(C), .TW(TW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_num_tiles   (i_num_tiles),
    .i_fifo_empty  (i_fifo_empty),
    .i_array_ready (i_array_ready),
    .o_read_enable (o_read_enable),
    .o_valid_mask  (o_valid_mask),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // model: phase 0 idle, 1 feeding, 2 flush, 3 done; progress counts completed steps
  int           m_phase = 0;
  int           m_prog = 0;
  int           m_total = 0;
  int           m_tiles = 0;
  logic [R-1:0] m_prev_re = '0;
  int           cnt [R];

  logic [R-1:0] last_re, last_vm;
  logic         last_busy, last_done;

  typedef struct {
    bit           st;
    logic [7:0]   nt;
    bit           rdy;
    logic [R-1:0] emp;
    logic [R-1:0] re;
    logic [R-1:0] vm;
    bit           busy;
    bit           done;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [R-1:0] win(input int k);
    logic [R-1:0] w;
    for (int r = 0; r < R; r++) w[r] = (k >= r) && (k < r + C);
    return w;
  endfunction

  task automatic drive(input bit st, input logic [7:0] nt, input bit rs,
                       input bit rdy, input logic [R-1:0] emp);
    logic [R-1:0] exp_re;
    bit stall;
    i_start = st; i_num_tiles = nt; i_rst = rs; i_array_ready = rdy; i_fifo_empty = emp;
    #1;
    exp_re = '0;
    stall = 1'b0;
    if (m_phase == 1) begin
      stall = !rdy || (|(win(m_prog % P) & emp));
      exp_re = stall ? '0 : win(m_prog % P);
    end
    last_re = o_read_enable; last_vm = o_valid_mask;
    last_busy = o_busy; last_done = o_done;
    if (chk_en) begin
      chk("model_re", 32'(last_re), 32'(exp_re));
      chk("model_vm", 32'(last_vm), 32'(m_prev_re));
      chk("model_busy", 32'(last_busy), 32'(m_phase != 0));
      chk("model_done", 32'(last_done), 32'(m_phase == 3));
      if (m_phase == 3)
        for (int r = 0; r < R; r++) chk("row_strobes", 32'(cnt[r]), 32'(C * m_tiles));
    end
    @(posedge i_clk);
    if (rs) begin
      m_phase = 0; m_prev_re = '0;
      for (int r = 0; r < R; r++) cnt[r] = 0;
    end else begin
      m_prev_re = exp_re;
      for (int r = 0; r < R; r++) cnt[r] += int'(last_re[r]);
      if (chk_en)
        for (int r = 1; r < R; r++) chk("skew_order", 32'(cnt[r] <= cnt[r-1]), 32'd1);
      case (m_phase)
        0: if (st && nt != 8'd0) begin
             m_phase = 1; m_prog = 0; m_tiles = int'(nt); m_total = int'(nt) * P;
             for (int r = 0; r < R; r++) cnt[r] = 0;
           end
        1: begin
             if (!stall) m_prog++;
             if (m_prog == m_total) m_phase = 2;
           end
        2: m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    @(negedge i_clk);
  endtask

  task automatic addv(input bit st, input bit rdy, input logic [R-1:0] re,
                      input logic [R-1:0] vm, input bit busy, input bit done);
    vec_t v;
    v.st = st; v.nt = 8'd1; v.rdy = rdy; v.emp = '0;
    v.re = re; v.vm = vm; v.busy = busy; v.done = done;
    tab.push_back(v);
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].st, tab[i].nt, 1'b0, tab[i].rdy, tab[i].emp);
      chk({nm, "_re"}, 32'(last_re), 32'(tab[i].re));
      chk({nm, "_vm"}, 32'(last_vm), 32'(tab[i].vm));
      chk({nm, "_busy"}, 32'(last_busy), 32'(tab[i].busy));
      chk({nm, "_done"}, 32'(last_done), 32'(tab[i].done));
    end
  endtask

  task automatic load_basic();
    tab.delete();
    addv(1, 1, 3'b000, 3'b000, 0, 0);
    addv(0, 1, 3'b001, 3'b000, 1, 0);
    addv(0, 1, 3'b011, 3'b001, 1, 0);
    addv(0, 1, 3'b111, 3'b011, 1, 0);
    addv(0, 1, 3'b111, 3'b111, 1, 0);
    addv(0, 1, 3'b110, 3'b111, 1, 0);
    addv(0, 1, 3'b100, 3'b110, 1, 0);
    addv(0, 1, 3'b000, 3'b100, 1, 0);
    addv(0, 1, 3'b000, 3'b000, 1, 1);
    addv(0, 1, 3'b000, 3'b000, 0, 0);
  endtask

  initial begin
    int feed, dn, seen;
    int rc [R];
    for (int r = 0; r < R; r++) cnt[r] = 0;
    @(negedge i_clk);
    drive(0, 8'd0, 1, 1, '0);
    chk_en = 1'b1;
    drive(0, 8'd0, 1, 1, '0);
    chk("rst_re", 32'(last_re), 32'd0);
    chk("rst_vm", 32'(last_vm), 32'd0);
    chk("rst_busy", 32'(last_busy), 32'd0);
    chk("rst_done", 32'(last_done), 32'd0);

    load_basic();
    run_table("basic");

    tab.delete();
    addv(1, 1, 3'b000, 3'b000, 0, 0);
    addv(0, 1, 3'b001, 3'b000, 1, 0);
    addv(0, 1, 3'b011, 3'b001, 1, 0);
    addv(0, 0, 3'b000, 3'b011, 1, 0);
    addv(0, 0, 3'b000, 3'b000, 1, 0);
    addv(0, 1, 3'b111, 3'b000, 1, 0);
    addv(0, 1, 3'b111, 3'b111, 1, 0);
    addv(0, 1, 3'b110, 3'b111, 1, 0);
    addv(0, 1, 3'b100, 3'b110, 1, 0);
    addv(0, 1, 3'b000, 3'b100, 1, 0);
    addv(0, 1, 3'b000, 3'b000, 1, 1);
    addv(0, 1, 3'b000, 3'b000, 0, 0);
    run_table("stall");

    // row 2 empty: harmless outside its window, freezes everything inside it
    drive(1, 8'd1, 0, 1, 3'b100);
    drive(0, 8'd1, 0, 1, 3'b100); chk("empty_t0", 32'(last_re), 32'b001);
    drive(0, 8'd1, 0, 1, 3'b100); chk("empty_t1", 32'(last_re), 32'b011);
    drive(0, 8'd1, 0, 1, 3'b100); chk("empty_stall_a", 32'(last_re), 32'b000);
    drive(0, 8'd1, 0, 1, 3'b100); chk("empty_stall_b", 32'(last_re), 32'b000);
    drive(0, 8'd1, 0, 1, 3'b000); chk("empty_resume", 32'(last_re), 32'b111);
    for (int i = 0; i < 6; i++) drive(0, 8'd0, 0, 1, '0);

    feed = 0; dn = 0;
    for (int r = 0; r < R; r++) rc[r] = 0;
    for (int i = 0; i < 24; i++) begin
      drive(i == 0, 8'd3, 0, 1, '0);
      if (last_re != '0) feed++;
      dn += int'(last_done);
      for (int r = 0; r < R; r++) rc[r] += int'(last_re[r]);
    end
    chk("multi_feed_cycles", 32'(feed), 32'd18);
    chk("multi_done_count", 32'(dn), 32'd1);
    for (int r = 0; r < R; r++) chk("multi_row_strobes", 32'(rc[r]), 32'd12);

    seen = 0;
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, 8'd0, 0, 1, '0);
      seen += int'(last_busy) + int'(last_done);
    end
    chk("zero_tiles_quiet", 32'(seen), 32'd0);

    feed = 0; dn = 0;
    for (int i = 0; i < 14; i++) begin
      drive(i == 0 || i == 3, (i == 0) ? 8'd1 : 8'd5, 0, 1, '0);
      if (last_re != '0) feed++;
      dn += int'(last_done);
    end
    chk("restart_ignored_feed", 32'(feed), 32'd6);
    chk("restart_ignored_done", 32'(dn), 32'd1);

    drive(1, 8'd3, 0, 1, '0);
    for (int i = 1; i < 10; i++) drive(0, 8'd3, 0, 1, '0);
    drive(0, 8'd3, 1, 1, '0);
    drive(0, 8'd3, 0, 1, '0);
    chk("midrst_re", 32'(last_re), 32'd0);
    chk("midrst_vm", 32'(last_vm), 32'd0);
    chk("midrst_busy", 32'(last_busy), 32'd0);
    chk("midrst_done", 32'(last_done), 32'd0);
    load_basic();
    run_table("after_rst");

    for (int i = 0; i < 3000; i++) begin
      logic [R-1:0] emp;
      emp = ($urandom_range(0, 3) == 0) ? R'($urandom_range(0, 7)) : '0;
      drive($urandom_range(0, 7) == 0, 8'($urandom_range(0, 3)),
            $urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, emp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
